// File: rtl/se_sram_srw_bytes_init.sv
// Single-port byte-lane SRAM that zero-sweeps itself after reset, with a registered read path and valid strobe.
// Define SE_SRAM_OUTPUT_REG_EN for a second output register stage (read latency 2 instead of 1).
module se_sram_srw_bytes_init #(
  parameter int unsigned           data_width    = 32,
  parameter int unsigned           address_width = 14,
  parameter int unsigned           byte_width    = 8,
  parameter logic [byte_width-1:0] clear_value   = '0
) (
  input  logic                                sram_clock,
  input  logic                                reset_n,
  input  logic                                sram_clock__enable,
  input  logic                                select,
  input  logic                                read_not_write,
  input  logic [address_width-1:0]            address,
  input  logic [data_width/byte_width-1:0]    write_enable,
  input  logic [data_width-1:0]               write_data,
  output logic [data_width-1:0]               data_out,
  output logic                                data_out_valid,
  output logic                                init_busy
);

  localparam int unsigned lanes = data_width / byte_width;
  localparam int unsigned depth = 1 << address_width;

  // Extra counter bit keeps the final sweep address from aliasing back to 0.
  localparam logic [address_width:0] last_addr = {1'b0, {address_width{1'b1}}};
  localparam logic [address_width:0] addr_one  = {{address_width{1'b0}}, 1'b1};
  localparam logic [data_width-1:0]  clear_word = {lanes{clear_value}};

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [address_width:0]   clear_addr_q, clear_addr_d;
  logic                     init_busy_q, init_busy_d;
  logic [data_width-1:0]    rd_data_q, rd_data_d;
  logic                     rd_vld_q, rd_vld_d;

  logic                     mem_we;
  logic [address_width-1:0] mem_addr;
  logic [data_width-1:0]    mem_wdata;
  logic [lanes-1:0]         mem_be;
  logic [data_width-1:0]    mem_rdata;

  // One narrow array per lane so each lane has a single write process.
  for (genvar g = 0; g < lanes; g++) begin : g_lane
    logic [byte_width-1:0] lane_mem [depth];

    always_ff @(posedge sram_clock) begin
      if (mem_we && mem_be[g]) begin
        lane_mem[mem_addr] <= mem_wdata[g*byte_width +: byte_width];
      end
    end

    assign mem_rdata[g*byte_width +: byte_width] = lane_mem[address];
  end

  always_comb begin
    state_d      = state_q;
    clear_addr_d = clear_addr_q;
    init_busy_d  = init_busy_q;
    rd_data_d    = rd_data_q;
    rd_vld_d     = rd_vld_q;
    mem_we       = 1'b0;
    mem_addr     = address;
    mem_wdata    = write_data;
    mem_be       = write_enable;

    if (sram_clock__enable) begin
      rd_vld_d = 1'b0;
      case (state_q)
        CLEAR: begin
          mem_we       = 1'b1;
          mem_addr     = clear_addr_q[address_width-1:0];
          mem_wdata    = clear_word;
          mem_be       = '1;
          clear_addr_d = clear_addr_q + addr_one;
          if (clear_addr_q == last_addr) begin
            state_d     = READY;
            init_busy_d = 1'b0;
          end
        end
        READY: begin
          if (select) begin
            if (read_not_write) begin
              rd_data_d = mem_rdata;
              rd_vld_d  = 1'b1;
            end else begin
              mem_we = 1'b1;
            end
          end
        end
        default: begin
          state_d = CLEAR;
        end
      endcase
    end
  end

  always_ff @(posedge sram_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= CLEAR;
      clear_addr_q <= '0;
      init_busy_q  <= 1'b1;
      rd_data_q    <= '0;
      rd_vld_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_addr_q <= clear_addr_d;
      init_busy_q  <= init_busy_d;
      rd_data_q    <= rd_data_d;
      rd_vld_q     <= rd_vld_d;
    end
  end

  assign init_busy = init_busy_q;

`ifdef SE_SRAM_OUTPUT_REG_EN
  logic [data_width-1:0] out_data_q, out_data_d;
  logic                  out_vld_q, out_vld_d;

  always_comb begin
    out_data_d = out_data_q;
    out_vld_d  = out_vld_q;
    if (sram_clock__enable) begin
      out_data_d = rd_data_q;
      out_vld_d  = rd_vld_q;
    end
  end

  always_ff @(posedge sram_clock or negedge reset_n) begin
    if (!reset_n) begin
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
    end else begin
      out_data_q <= out_data_d;
      out_vld_q  <= out_vld_d;
    end
  end

  assign data_out       = out_data_q;
  assign data_out_valid = out_vld_q;
`else
  assign data_out       = rd_data_q;
  assign data_out_valid = rd_vld_q;
`endif

endmodule
